pdm_cic_decim: RTL and testbench



---
 rtl/pdm_cic_decim_if.sv | 16 +
 rtl/pdm_cic_decim.sv | 131 +++++++++++++
 tb/tb_pdm_cic_decim.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pdm_cic_decim_if.sv
// PDM in / PCM out bundle for pdm_cic_decim.
// master drives samples and sync; slave (the decimator) returns PCM frames.
interface pdm_cic_decim_if #(
  parameter int NCH   = 20,
  parameter int OUT_W = 16
);
  logic                 pdm_valid;
  logic [NCH-1:0]       pdm_in;
  logic                 sync;
  logic [NCH*OUT_W-1:0] y_out;
  logic                 y_valid;
  logic                 settled;

  modport master (output pdm_valid, pdm_in, sync, input y_out, y_valid, settled);
  modport slave  (input pdm_valid, pdm_in, sync, output y_out, y_valid, settled);
endinterface

// File: rtl/pdm_cic_decim.sv
// Multi-channel PDM-to-PCM CIC decimator, single clock, sample-strobe driven.
// One shared decimation counter / valid pipeline, one lane per channel.
// Optional macro PDM_CIC_CH_MASK_EN adds a per-channel enable port ch_en.

// Per-channel CIC datapath: ORDER integrators, capture register,
// ORDER pipelined comb stages and the output word register.
module pdm_cic_lane #(
  parameter int ORDER = 4,
  parameter int ACC_W = 18,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_valid,
  input  logic             bit_in,
  input  logic             ev,
  input  logic [ORDER:0]   vld,
  output logic [OUT_W-1:0] y
);
  localparam int SHIFT = ACC_W - OUT_W;

  logic [ORDER-1:0][ACC_W-1:0] integ, integ_nx, dly, cmb, cin;
  logic [ACC_W-1:0]            cap, x, acc;
  logic signed [ACC_W-1:0]     last;

  // bit 1 -> +1, bit 0 -> -1 (all ones in two's complement)
  assign x    = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};
  assign last = cmb[ORDER-1];

  // integrator cascade including the current sample; comb stage inputs
  always_comb begin
    integ_nx = integ;
    cin      = '0;
    acc      = x;
    for (int k = 0; k < ORDER; k++) begin
      acc         = integ[k] + acc;
      integ_nx[k] = acc;
    end
    cin[0] = cap;
    for (int k = 1; k < ORDER; k++) cin[k] = cmb[k-1];
  end

  // integrate on strobes, capture on events, walk the comb pipeline
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      integ <= '0;
      cap   <= '0;
      dly   <= '0;
      cmb   <= '0;
      y     <= '0;
    end else begin
      if (pdm_valid) integ <= integ_nx;
      if (ev)        cap   <= integ_nx[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        if (vld[k]) begin
          cmb[k] <= cin[k] - dly[k];
          dly[k] <= cin[k];
        end
      end
      if (vld[ORDER]) y <= OUT_W'(last >>> SHIFT);
    end
  end
endmodule

module pdm_cic_decim #(
  parameter int NCH   = 20,
  parameter int ORDER = 4,
  parameter int DECIM = 16,
  parameter int OUT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
`ifdef PDM_CIC_CH_MASK_EN
  input  logic [NCH-1:0] ch_en,
`endif
  pdm_cic_decim_if.slave bus
);
  localparam int ACC_W  = ORDER * $clog2(DECIM) + 2;
  localparam int CW     = $clog2(DECIM);
  localparam int FW     = $clog2(ORDER + 2);
  // vld_pipe[0] capture, [1..ORDER] comb stages, [ORDER+1] output word
  localparam int STAGES = ORDER + 1;

  logic [CW-1:0]               dcnt;
  logic [FW-1:0]               fcnt;
  logic [STAGES:0]             vld_pipe;
  logic                        ev;
  logic [NCH-1:0]              lane_en;
  logic [NCH-1:0][OUT_W-1:0]   y_w;

`ifdef PDM_CIC_CH_MASK_EN
  assign lane_en = ch_en;
`else
  assign lane_en = '1;
`endif

  // sync overrides a would-be event on the same edge
  assign ev          = bus.pdm_valid && !bus.sync && (dcnt == CW'(DECIM - 1));
  assign bus.y_out   = y_w;
  assign bus.y_valid = vld_pipe[STAGES];
  assign bus.settled = (fcnt == FW'(ORDER + 1));

  // decimation phase, valid shift register and saturating frame count
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt     <= '0;
      fcnt     <= '0;
      vld_pipe <= '0;
    end else begin
      if (bus.sync)           dcnt <= bus.pdm_valid ? CW'(1) : '0;
      else if (ev)            dcnt <= '0;
      else if (bus.pdm_valid) dcnt <= dcnt + CW'(1);
      vld_pipe <= {vld_pipe[STAGES-1:0], ev};
      if (vld_pipe[STAGES-1] && fcnt != FW'(ORDER + 1)) fcnt <= fcnt + FW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    pdm_cic_lane #(.ORDER(ORDER), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (lane_en[i]),
      .pdm_valid (bus.pdm_valid),
      .bit_in    (bus.pdm_in[i]),
      .ev        (ev),
      .vld       (vld_pipe[STAGES-1:0]),
      .y         (y_w[i])
    );
  end
endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed + randomized bench for pdm_cic_decim.
// Reference: each frame is the FIR ((1-z^-D)/(1-z^-1))^N applied to the full
// sample history (unbounded integers), valid whenever the last N decimation
// intervals are regular; timing is checked against event edge + ORDER+1.
module tb_pdm_cic_decim;
  localparam int NCH   = 20;
  localparam int ORDER = 4;
  localparam int DECIM = 16;
  localparam int OUT_W = 16;
  localparam int ACC_W = ORDER * $clog2(DECIM) + 2;
  localparam int SHIFT = ACC_W - OUT_W;
  localparam int L     = ORDER * (DECIM - 1) + 1;
  localparam int VW    = NCH * OUT_W;

  typedef struct {
    int          due;
    bit          chk;
    logic [VW-1:0] y;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
`ifdef PDM_CIC_CH_MASK_EN
  logic [NCH-1:0] ch_en = '1;
`endif

  pdm_cic_decim_if #(.NCH(NCH), .OUT_W(OUT_W)) bus ();

  pdm_cic_decim #(.NCH(NCH), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef PDM_CIC_CH_MASK_EN
    .ch_en (ch_en),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  longint         h[L];
  exp_t           q[$];
  logic [NCH-1:0] hist[$];
  int             ev_list[$];
  int             phase, frames, edge_n, last_yv, prev_yv;
  int             checks, errors;
  logic [VW-1:0]  last_exp;
  bit             last_chk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference output for an event at sample index n (samples numbered from 1)
  function automatic logic [VW-1:0] fir(int n);
    logic [VW-1:0] r;
    longint acc;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = 0;
      for (int j = 0; j < L; j++)
        if (n - j >= 1) acc += h[j] * (hist[n-j-1][c] ? 64'sd1 : -64'sd1);
      r[c*OUT_W +: OUT_W] = OUT_W'(acc >>> SHIFT);
    end
    return r;
  endfunction

  // one clock: drive, update the model at the edge, check at the falling edge
  task automatic step(input bit v, input logic [NCH-1:0] b, input bit s, input bit r);
    bit   evt, ok;
    int   n, m, t;
    exp_t e;
    rst = r; bus.pdm_valid = v; bus.pdm_in = b; bus.sync = s;
    @(posedge clk);
    edge_n++;
    evt = 0;
    if (r) begin
      q.delete(); hist.delete(); ev_list.delete();
      phase = 0; frames = 0; last_exp = '0; last_chk = 1;
    end else begin
      if (v) hist.push_back(b);
      if (s) phase = v ? 1 : 0;
      else if (v) begin
        if (phase == DECIM - 1) begin evt = 1; phase = 0; end
        else phase++;
      end
      if (evt) begin
        n = hist.size(); m = ev_list.size(); ok = 1;
        for (int k = 1; k <= ORDER; k++) begin
          t = n - k * DECIM;
          if (m - k >= 0) ok &= (ev_list[m-k] == t);
          else            ok &= (t <= 0);
        end
        ev_list.push_back(n);
        e.due = edge_n + ORDER + 1; e.chk = ok; e.y = ok ? fir(n) : '0;
        q.push_back(e);
      end
    end
    @(negedge clk);
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      chk("y_valid_hi", VW'(bus.y_valid), VW'(1));
      frames++; prev_yv = last_yv; last_yv = edge_n;
      if (e.chk) chk("y_out", bus.y_out, e.y);
      last_exp = e.y; last_chk = e.chk;
    end else begin
      chk("y_valid_lo", VW'(bus.y_valid), VW'(0));
      if (last_chk) chk("y_hold", bus.y_out, last_exp);
    end
    chk("settled", VW'(bus.settled), VW'(frames >= ORDER + 1));
  endtask

  initial begin
    longint        tmp[L];
    logic [VW-1:0] pos_v, t2_v;
    logic [NCH-1:0] b;
    bit            alt;
    int            s_edge;
    checks = 0; errors = 0; edge_n = 0; last_yv = -1; prev_yv = -1;
    phase = 0; frames = 0; last_exp = '0; last_chk = 1;
    bus.pdm_valid = 0; bus.pdm_in = '0; bus.sync = 0;

    // impulse response of the CIC: boxcar of length DECIM convolved ORDER times
    for (int j = 0; j < L; j++) h[j] = (j == 0) ? 64'sd1 : 64'sd0;
    for (int o = 0; o < ORDER; o++) begin
      for (int j = 0; j < L; j++) begin
        tmp[j] = 0;
        for (int k = 0; k < DECIM; k++) if (j - k >= 0) tmp[j] += h[j-k];
      end
      for (int j = 0; j < L; j++) h[j] = tmp[j];
    end
    for (int c = 0; c < NCH; c++) begin
      pos_v[c*OUT_W +: OUT_W] = 16'h4000;
      t2_v[c*OUT_W +: OUT_W]  = (c == 1) ? 16'h4000 : (c == 2) ? 16'h0000 : 16'hC000;
    end

    // reset state
    repeat (3) step(0, '0, 0, 1);
    chk("rst_y_out", bus.y_out, '0);
    chk("rst_settled", VW'(bus.settled), VW'(0));

    // all-ones every cycle: first y_valid at edge 16+5 after first sample
    s_edge = edge_n;
    repeat (12 * DECIM + ORDER + 2) step(1, '1, 0, 0);
    chk("t1_full_scale", bus.y_out, pos_v);
    chk("t1_settled", VW'(bus.settled), VW'(1));
    chk("t1_first_lat", VW'(ev_list[0]), VW'(DECIM));

    // mixed channels, pdm_valid every 3rd cycle, garbage between strobes
    repeat (2) step(0, '0, 0, 1);
    alt = 1;
    for (int i = 0; i < 12 * DECIM * 3; i++) begin
      if (i % 3 == 0) begin
        b = '0; b[1] = 1'b1; b[2] = alt; alt = ~alt;
        step(1, b, 0, 0);
      end else step(0, NCH'($urandom), 0, 0);
    end
    repeat (8) step(0, NCH'($urandom), 0, 0);
    chk("t2_values", bus.y_out, t2_v);
    chk("t2_period", VW'(last_yv - prev_yv), VW'(3 * DECIM));

    // sync with pdm_valid at dcnt=10: next event 15 strobes later
    repeat (2) step(0, '0, 0, 1);
    repeat (3 * DECIM + 10) step(1, '1, 0, 0);
    step(1, '1, 1, 0);
    s_edge = edge_n;
    repeat (15) step(1, '1, 0, 0);
    repeat (8) step(0, '0, 0, 0);
    chk("t3_sync_evt", VW'(last_yv), VW'(s_edge + 15 + ORDER + 1));

    // reset 2 cycles after an event: that frame must never appear
    repeat (2) step(0, '0, 0, 1);
    repeat (6 * DECIM) step(1, '1, 0, 0);
    step(1, '1, 0, 0);
    step(1, '1, 0, 1);
    chk("t4_rst_y_out", bus.y_out, '0);
    chk("t4_rst_settled", VW'(bus.settled), VW'(0));
    repeat (8) step(0, '0, 0, 0);
    repeat (6 * DECIM + ORDER + 2) step(1, '1, 0, 0);
    chk("t4_restart", bus.y_out, pos_v);

    // random bits on all channels with random strobe gaps
    repeat (2) step(0, '0, 0, 1);
    for (int i = 0; i < 20000; i++)
      step(($urandom % 4) != 0, NCH'($urandom), 0, 0);
    repeat (8) step(0, '0, 0, 0);
    chk("t5_settled", VW'(bus.settled), VW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
